// File: rtl/act_lut_pipe.sv
// act_lut_pipe
// Pipelined multi-lane activation unit: tanh, sigmoid, ReLU or bypass on
// LANES signed fixed-point samples per beat. Three register stages,
// valid/ready streaming and a globally stalled pipeline. tanh values in the
// mid range come from a runtime-loadable segment LUT. Sigmoid reuses the
// tanh path through sigmoid(x) = (1 + tanh(x/2)) / 2.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   input beat handshake
//   in_mode               0 tanh, 1 sigmoid, 2 relu, 3 bypass (whole beat)
//   in_data               LANES samples, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid / out_ready output beat handshake
//   out_data              results, same lane packing as in_data
//   lut_wr_en/addr/data   LUT write port (tanh magnitude per segment)
module act_lut_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int LANES      = 4,
  parameter int LUT_DEPTH  = 32,
  parameter logic [DATA_WIDTH-1:0] LIN_THRESH = 16'h0800,
  parameter logic [DATA_WIDTH-1:0] SAT_THRESH = 16'h3000,
  parameter int STEP_SHIFT = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_mode,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  input  logic                          lut_wr_en,
  input  logic [$clog2(LUT_DEPTH)-1:0]  lut_wr_addr,
  input  logic [DATA_WIDTH-1:0]         lut_wr_data
);

  localparam int DW = DATA_WIDTH;
  localparam int W1 = DATA_WIDTH + 1;
  localparam int AW = $clog2(LUT_DEPTH);
  localparam int VW = LANES * DATA_WIDTH;

  localparam logic [DW-1:0]        ONE     = DW'(1) << FRAC_BITS;
  localparam logic [DW-1:0]        MIN_VAL = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        MAG_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [W1-1:0]        SEG_MAX = W1'(LUT_DEPTH - 1);
  localparam logic [AW-1:0]        IDX_MAX = AW'(LUT_DEPTH - 1);
  localparam logic signed [W1-1:0] ONE_EXT = {1'b0, ONE};

  typedef enum logic [1:0] {
    MODE_TANH    = 2'd0,
    MODE_SIGMOID = 2'd1,
    MODE_RELU    = 2'd2,
    MODE_BYPASS  = 2'd3
  } mode_t;

  logic            advance;
  mode_t           in_mode_e;

  logic [VW-1:0]   s1_mag_d;
  logic [LANES-1:0] s1_sign_d;
  logic            s1_valid;
  mode_t           s1_mode;
  logic [VW-1:0]   s1_x;
  logic [VW-1:0]   s1_mag;
  logic [LANES-1:0] s1_sign;

  logic [VW-1:0]   s2_t_d;
  logic            s2_valid;
  mode_t           s2_mode;
  logic [VW-1:0]   s2_x;
  logic [VW-1:0]   s2_t;
  logic [LANES-1:0] s2_sign;

  logic [VW-1:0]   out_data_d;

  logic [DW-1:0]   lut [LUT_DEPTH];

  // Global stall: every stage moves together, and only when the output
  // register is empty or being drained this cycle.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign in_mode_e = mode_t'(in_mode);

  // Stage 1 logic: halve the input for sigmoid, then take the magnitude.
  // The most negative value has no positive twin, so it saturates.
  for (genvar g = 0; g < LANES; g++) begin : g_stage1
    logic [DW-1:0]        x;
    logic [DW-1:0]        xs;
    logic signed [W1-1:0] neg;

    assign x   = in_data[g*DW +: DW];
    assign xs  = (in_mode_e == MODE_SIGMOID) ? {x[DW-1], x[DW-1:1]} : x;
    assign neg = -$signed({xs[DW-1], xs});

    assign s1_sign_d[g]          = xs[DW-1];
    assign s1_mag_d[g*DW +: DW]  = !xs[DW-1]        ? xs      :
                                   (xs == MIN_VAL)  ? MAG_MAX : DW'(neg);
  end

  // Stage 2 logic: identity near zero, saturation far out, LUT segment in
  // between. Each lane has its own combinational read of the table.
  for (genvar g = 0; g < LANES; g++) begin : g_stage2
    logic [DW-1:0] mag;
    logic [W1-1:0] seg;
    logic [AW-1:0] idx;

    assign mag = s1_mag[g*DW +: DW];
    assign seg = ({1'b0, mag} - {1'b0, LIN_THRESH}) >> STEP_SHIFT;
    assign idx = (seg > SEG_MAX) ? IDX_MAX : seg[AW-1:0];

    assign s2_t_d[g*DW +: DW] = (mag <  LIN_THRESH) ? mag :
                                (mag >= SAT_THRESH) ? ONE : lut[idx];
  end

  // Stage 3 logic: reapply the sign and shape the result per mode.
  for (genvar g = 0; g < LANES; g++) begin : g_stage3
    logic [DW-1:0]        x;
    logic [DW-1:0]        t;
    logic signed [W1-1:0] t_signed;
    logic signed [W1-1:0] sum;
    logic [DW-1:0]        y;

    assign x        = s2_x[g*DW +: DW];
    assign t        = s2_t[g*DW +: DW];
    assign t_signed = s2_sign[g] ? -$signed({1'b0, t}) : $signed({1'b0, t});
    assign sum      = ONE_EXT + t_signed;

    always_comb begin
      y = x;
      case (s2_mode)
        MODE_TANH:    y = DW'(t_signed);
        MODE_SIGMOID: y = DW'(sum >>> 1);
        MODE_RELU:    y = x[DW-1] ? '0 : x;
        default:      y = x;
      endcase
    end

    assign out_data_d[g*DW +: DW] = y;
  end

  // Pipeline registers. Reset drops every in-flight beat; the data regs are
  // cleared too so out_data reads zero straight after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_TANH;
      s1_x      <= '0;
      s1_mag    <= '0;
      s1_sign   <= '0;
      s2_valid  <= 1'b0;
      s2_mode   <= MODE_TANH;
      s2_x      <= '0;
      s2_t      <= '0;
      s2_sign   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_mode   <= in_mode_e;
      s1_x      <= in_data;
      s1_mag    <= s1_mag_d;
      s1_sign   <= s1_sign_d;
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_x      <= s1_x;
      s2_t      <= s2_t_d;
      s2_sign   <= s1_sign;
      out_valid <= s2_valid;
      out_data  <= out_data_d;
    end
  end

  // LUT storage: written regardless of stall, not reset. A lookup in the
  // same cycle as a write sees the old entry. The address width spans the
  // depth exactly, so no out-of-range index can be presented.
  always_ff @(posedge clk) begin
    if (lut_wr_en) begin
      lut[lut_wr_addr] <= lut_wr_data;
    end
  end

endmodule

// File: tb/tb_act_lut_pipe.sv
// tb_act_lut_pipe
// Directed and randomised self-checking bench for act_lut_pipe at default
// parameters (16-bit samples, 12 fractional bits, 4 lanes, 32-entry LUT).
// Inputs change 1 time unit after a rising edge; outputs are observed then
// or on the falling edge. Completed output transfers are collected in got_q.
module tb_act_lut_pipe;

  localparam int DW     = 16;
  localparam int LANES  = 4;
  localparam int VW     = DW * LANES;
  localparam int NBEATS = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [VW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          lut_wr_en;
  logic [4:0]    lut_wr_addr;
  logic [DW-1:0] lut_wr_data;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] got_q[$];
  logic [VW-1:0] exp_q[$];
  logic [DW-1:0] lut_model [32];
  logic          done;

  act_lut_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data)
  );

  always #5 clk = ~clk;

  // Record every beat that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(out_data);
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model of one lane, written in plain integer arithmetic.
  function automatic logic [DW-1:0] ref_lane(input logic [1:0] m, input logic [DW-1:0] x);
    int xi, xs, mag, t, st, y, idx;
    xi  = int'($signed(x));
    xs  = (m == 2'd1) ? (xi >>> 1) : xi;
    mag = (xs < 0) ? -xs : xs;
    if (mag > 32767) mag = 32767;
    if (mag < 'h800) t = mag;
    else if (mag >= 'h3000) t = 'h1000;
    else begin
      idx = (mag - 'h800) / 512;
      if (idx > 31) idx = 31;
      t = int'(lut_model[idx]);
    end
    st = (xs < 0) ? -t : t;
    case (m)
      2'd0:    y = st;
      2'd1:    y = (4096 + st) >>> 1;
      2'd2:    y = (xi < 0) ? 0 : xi;
      default: y = xi;
    endcase
    return y[DW-1:0];
  endfunction

  function automatic logic [VW-1:0] ref_beat(input logic [1:0] m, input logic [VW-1:0] d);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = ref_lane(m, d[i*DW +: DW]);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_lane();
    int m;
    case ($urandom_range(0, 5))
      0:       return 16'($urandom);
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      default: begin
        m = int'($urandom_range(0, 'h3400));
        return ($urandom_range(0, 1) == 1) ? 16'(-m) : 16'(m);
      end
    endcase
  endfunction

  function automatic logic [VW-1:0] bp_in(input int k);
    return {16'(k), 16'h3000, 16'(-(k * 16)), 16'(k * 16)};
  endfunction

  function automatic logic [VW-1:0] bp_exp(input int k);
    return {16'(k), 16'h1000, 16'(-(k * 16)), 16'(k * 16)};
  endfunction

  task automatic lut_write(input logic [4:0] a, input logic [DW-1:0] d);
    lut_wr_en   = 1'b1;
    lut_wr_addr = a;
    lut_wr_data = d;
    @(posedge clk); #1;
    lut_wr_en    = 1'b0;
    lut_model[a] = d;
  endtask

  // Present a beat and hold it until accepted; in_valid stays high on return.
  task automatic send(input logic [1:0] m, input logic [VW-1:0] d);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL send_accept: in_ready=%b after %0d cycles, required 1", acc, n);
    end
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out_data: got %h, expected 0", out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_identity_saturation();
    logic [VW-1:0] exp;
    logic [VW-1:0] obs;
    int cyc;
    exp = {16'hF000, 16'hF000, 16'h1000, 16'h0400};
    got_q.delete();
    send(2'd0, {16'h8000, 16'hD000, 16'h3000, 16'h0400});
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles, expected 3", cyc);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("[TB] FAIL ident_sat: got %h, expected %h", out_data, exp);
    end
    wait_outputs(1, 5);
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("[TB] FAIL ident_sat_count: got %0d, expected 1", got_q.size());
    end
    obs = (got_q.size() > 0) ? got_q[0] : '0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL ident_sat_transfer: got %h, expected %h", obs, exp);
    end
  endtask

  // 0x0A00 and 0x0BFF both sit (0x200..0x3FF above LIN_THRESH) in segment 1.
  task automatic test_lut_path();
    logic [VW-1:0] exp;
    logic [VW-1:0] obs;
    exp = {16'h0A29, 16'h0A29, 16'hF7FE, 16'h0802};
    lut_write(5'd0, 16'h0802);
    lut_write(5'd1, 16'h0A29);
    lut_write(5'd2, 16'h0A29);
    lut_write(5'd19, 16'h0FFF);
    got_q.delete();
    send(2'd0, {16'h0BFF, 16'h0A00, 16'hF800, 16'h0800});
    in_valid = 1'b0;
    wait_outputs(1, 10);
    obs = (got_q.size() > 0) ? got_q[0] : '0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL lut_path: got %h, expected %h", obs, exp);
    end
  endtask

  // Beat A does its lookup in the cycle lut[0] is rewritten, so it sees the
  // old entry; beat B right behind it sees the new one.
  task automatic test_lut_collision();
    logic [VW-1:0] exp_a, exp_b, obs;
    exp_a = {16'h0802, 16'hF801, 16'h07FF, 16'h0802};
    exp_b = {16'h0FFF, 16'h0900, 16'h0900, 16'h0900};
    got_q.delete();
    send(2'd0, {16'h0800, 16'hF801, 16'h07FF, 16'h0800});
    lut_wr_en   = 1'b1;
    lut_wr_addr = 5'd0;
    lut_wr_data = 16'h0900;
    send(2'd0, {16'h2FFF, 16'h0800, 16'h0800, 16'h0800});
    lut_wr_en    = 1'b0;
    lut_model[0] = 16'h0900;
    in_valid     = 1'b0;
    wait_outputs(2, 10);
    obs = (got_q.size() > 0) ? got_q[0] : '0;
    checks++;
    if (obs !== exp_a) begin
      errors++;
      $display("[TB] FAIL lut_old_value: got %h, expected %h", obs, exp_a);
    end
    obs = (got_q.size() > 1) ? got_q[1] : '0;
    checks++;
    if (obs !== exp_b) begin
      errors++;
      $display("[TB] FAIL lut_new_value: got %h, expected %h", obs, exp_b);
    end
  endtask

  task automatic test_modes();
    logic [VW-1:0] exp [3];
    logic [VW-1:0] obs;
    exp[0] = {16'h1000, 16'h0900, 16'h0000, 16'h0800};
    exp[1] = {16'h0000, 16'h7FFF, 16'h1234, 16'h0000};
    exp[2] = {16'h8000, 16'h0001, 16'h1234, 16'hF000};
    got_q.delete();
    send(2'd1, {16'h7FFF, 16'h0400, 16'h8000, 16'h0000});
    send(2'd2, {16'h8000, 16'h7FFF, 16'h1234, 16'hF000});
    send(2'd3, {16'h8000, 16'h0001, 16'h1234, 16'hF000});
    in_valid = 1'b0;
    wait_outputs(3, 20);
    checks++;
    if (got_q.size() !== 3) begin
      errors++;
      $display("[TB] FAIL modes_count: got %0d, expected 3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      obs = (got_q.size() > i) ? got_q[i] : '0;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("[TB] FAIL modes_beat%0d: got %h, expected %h", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] obs;
    got_q.delete();
    out_ready = 1'b1;
    fork
      begin : bp_source
        for (int k = 1; k <= 6; k++) send(2'd0, bp_in(k));
        in_valid = 1'b0;
      end
      begin : bp_sink
        int c;
        logic [VW-1:0] held;
        c = 0;
        while (!out_valid && c < 20) begin
          @(posedge clk); #1;
          c++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          checks++;
          if (out_data !== held) begin
            errors++;
            $display("[TB] FAIL stall_data_c%0d: got %h, expected %h", i, out_data, held);
          end
          checks++;
          if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_valid_c%0d: got %b, expected 1", i, out_valid);
          end
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_in_ready_c%0d: got %b, expected 0", i, in_ready);
          end
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(6, 40);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (got_q.size() !== 6) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d, expected 6", got_q.size());
    end
    for (int k = 1; k <= 6; k++) begin
      obs = (got_q.size() >= k) ? got_q[k-1] : '0;
      checks++;
      if (obs !== bp_exp(k)) begin
        errors++;
        $display("[TB] FAIL bp_beat%0d: got %h, expected %h", k, obs, bp_exp(k));
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic saw;
    int cyc;
    logic [VW-1:0] exp;
    exp = {16'hFF00, 16'h0100, 16'h1000, 16'hF000};
    got_q.delete();
    out_ready = 1'b1;
    send(2'd3, {4{16'h1111}});
    send(2'd3, {4{16'h2222}});
    send(2'd3, {4{16'h3333}});
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_valid: got %b, expected 1", out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_valid: got %b, expected 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset_data: got %h, expected 0", out_data);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flushed_valid: got %b, expected 0", saw);
    end
    send(2'd0, {16'hFF00, 16'h0100, 16'h3000, 16'hD000});
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("[TB] FAIL post_reset_latency: got %0d cycles, expected 3", cyc);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("[TB] FAIL post_reset_data: got %h, expected %h", out_data, exp);
    end
    wait_outputs(1, 5);
    @(posedge clk); #1;
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("[TB] FAIL post_reset_count: got %0d, expected 1", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] obs;
    for (int i = 0; i < 32; i++) lut_write(5'(i), 16'($urandom_range(0, 'h1000)));
    got_q.delete();
    exp_q.delete();
    done = 1'b0;
    fork
      begin : rnd_source
        logic [1:0]    m;
        logic [VW-1:0] d;
        for (int n = 0; n < NBEATS; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk); #1;
            end
          end
          m = 2'($urandom_range(0, 3));
          for (int l = 0; l < LANES; l++) d[l*DW +: DW] = rand_lane();
          send(m, d);
          exp_q.push_back(ref_beat(m, d));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin : rnd_sink
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(NBEATS, 200);
    checks++;
    if (got_q.size() !== NBEATS) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d, expected %0d", got_q.size(), NBEATS);
    end
    for (int i = 0; i < NBEATS; i++) begin
      obs = (got_q.size() > i) ? got_q[i] : '0;
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL random_beat%0d: got %h, expected %h", i, obs, exp_q[i]);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_mode     = 2'd0;
    in_data     = '0;
    out_ready   = 1'b1;
    lut_wr_en   = 1'b0;
    lut_wr_addr = '0;
    lut_wr_data = '0;
    done        = 1'b0;
    for (int i = 0; i < 32; i++) lut_model[i] = '0;

    $display("[TB] starting act_lut_pipe bench");
    test_reset();
    test_identity_saturation();
    test_lut_path();
    test_lut_collision();
    test_modes();
    test_backpressure();
    test_reset_midstream();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
